uart_tx_arbiter: RTL

//  Shares one uart_top transmitter among NUM_REQ requesters using round-robin arbitration.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared state encoding and index-width helper for the UART arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_pick
// Purpose  : Combinational round-robin picker: first asserted req at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [IDXW-1:0]    idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot_w;

    // Rotate so that bit 0 corresponds to the requester at ptr.
    assign rot_w = NUM_REQ'({req, req} >> ptr);

    always_comb begin : p_pick
        int s;
        s   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && rot_w[k[IDXW-1:0]]) begin
                any = 1'b1;
                s   = int'(ptr) + k;
                if (s >= NUM_REQ) begin
                    s = s - NUM_REQ;
                end
                idx = s[IDXW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one uart_top transmitter with message locking,
//            plus owner-tagged draining of the uart_top receive side.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int BUSY_TMO = 16,
    parameter  int LOCK_TMO = 4096,
    localparam int IDXW     = idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [IDXW-1:0]      owner,
    output logic                 active,
    output logic                 tmo_err,
    output logic [7:0]           uart_data_in,
    output logic                 uart_wr_en,
    input  logic                 uart_busy,
    input  logic                 uart_rdy,
    input  logic [7:0]           uart_dout,
    output logic                 uart_rdy_clr,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic [IDXW-1:0]      rx_owner
);

    localparam int CNT_MAX = (BUSY_TMO > LOCK_TMO) ? BUSY_TMO : LOCK_TMO;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic              active_q, active_d;
    logic              last_q, last_d;
    logic              tmo_err_q, tmo_err_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [IDXW-1:0]   rx_owner_q, rx_owner_d;
    logic              rx_valid_q, rx_valid_d;
    logic              clr_pend_q, clr_pend_d;

    logic [IDXW-1:0]   pick_idx_w;
    logic              pick_any_w;
    logic [IDXW-1:0]   next_ptr_w;
    logic              release_w;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (pick_idx_w),
        .any (pick_any_w)
    );

    assign next_ptr_w = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + IDXW'(1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        active_d  = active_q;
        last_d    = last_q;
        tmo_err_d = tmo_err_q;
        cnt_d     = '0;
        release_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_w) begin
                    owner_d  = pick_idx_w;
                    active_d = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                last_d  = req_last[owner_q];
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNTW'(BUSY_TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    release_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (last_q) begin
                        release_w = 1'b1;
                    end else if (req[owner_q]) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (req[owner_q]) begin
                    state_d = ST_SEND;
                end else if (cnt_q == CNTW'(LOCK_TMO - 1)) begin
                    release_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // owner_q is deliberately kept so rx tagging still reflects the last grant.
        if (release_w) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            rr_ptr_d = next_ptr_w;
        end
    end

    // One capture per rdy: the cycle in which rdy_clr is driven cannot capture again.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_owner_d = rx_owner_q;
        rx_valid_d = 1'b0;
        clr_pend_d = 1'b0;
        if (uart_rdy && !clr_pend_q) begin
            rx_data_d  = uart_dout;
            rx_owner_d = owner_q;
            rx_valid_d = 1'b1;
            clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            active_q   <= 1'b0;
            last_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_owner_q <= '0;
            rx_valid_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            active_q   <= active_d;
            last_q     <= last_d;
            tmo_err_q  <= tmo_err_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_owner_q <= rx_owner_d;
            rx_valid_q <= rx_valid_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign uart_wr_en   = (state_q == ST_SEND);
    assign uart_data_in = uart_wr_en ? req_data[{owner_q, 3'b000} +: 8] : 8'h00;
    assign ack          = uart_wr_en ? (NUM_REQ'(1) << owner_q) : '0;
    assign owner        = owner_q;
    assign active       = active_q;
    assign tmo_err      = tmo_err_q;
    assign uart_rdy_clr = clr_pend_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_owner     = rx_owner_q;

endmodule
`default_nettype wire
